// File: rtl/fifo_nibble_tx_if.sv
// fifo_nibble_tx_if: FIFO read port, serial line and status bundle for fifo_nibble_tx
interface fifo_nibble_tx_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              tx_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd;
  logic              tx;
  logic              busy;
  logic [CNT_W-1:0]  frames_sent;
  modport master (input tx_en, fifo_empty, fifo_dout, output fifo_rd, tx, busy, frames_sent);
  modport slave  (output tx_en, fifo_empty, fifo_dout, input fifo_rd, tx, busy, frames_sent);
endinterface

// File: rtl/fifo_nibble_tx.sv
// fifo_nibble_tx: one FIFO read per frame, each nibble sent as an async serial frame on tx
// Define TX_PARITY_EN to append an even-parity bit between the data bits and the stop bit.
module fifo_nibble_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input logic              clk,
  input logic              reset,
  fifo_nibble_tx_if.master bus
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t            state;
  logic [TW-1:0]     timer;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] sh;
  logic              tx;
  logic              fifo_rd;
  logic              busy;
  logic [CNT_W-1:0]  frames_sent;
  logic              last;
`ifdef TX_PARITY_EN
  logic              par;
`endif
  assign last            = timer == TW'(CLKS_PER_BIT - 1);
  assign bus.tx          = tx;
  assign bus.fifo_rd     = fifo_rd;
  assign bus.busy        = busy;
  assign bus.frames_sent = frames_sent;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      tx          <= 1'b1;
      fifo_rd     <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
`ifdef TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      // timer only runs while a bit is on the line and restarts at every bit boundary
      timer <= (state inside {START, DATA, PARITY, STOP} && !last) ? timer + 1'b1 : '0;
      case (state)
        IDLE: if (bus.tx_en && !bus.fifo_empty) begin
          fifo_rd <= 1'b1;
          busy    <= 1'b1;
          state   <= FETCH;
        end
        FETCH: begin
          fifo_rd <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          sh    <= bus.fifo_dout;
`ifdef TX_PARITY_EN
          par   <= ^bus.fifo_dout;
`endif
          tx    <= 1'b0;
          state <= START;
        end
        START: if (last) begin
          tx      <= sh[0];
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (last) begin
          sh      <= sh >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == BW'(DATA_W - 1)) begin
`ifdef TX_PARITY_EN
            tx    <= par;
            state <= PARITY;
`else
            tx    <= 1'b1;
            state <= STOP;
`endif
          end else tx <= sh[1];
        end
        PARITY: if (last) begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: if (last) begin
          busy        <= 1'b0;
          frames_sent <= frames_sent + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_nibble_tx.sv
// tb_fifo_nibble_tx: directed frames against a frame-level model plus hand-computed waveform checks
module tb_fifo_nibble_tx;
  localparam int CPB = 4;
  localparam int DW  = 4;
`ifdef TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int TOT = 2 + NB * CPB;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  fifo_nibble_tx_if #(.DATA_W(DW), .CNT_W(8)) ifc();
  fifo_nibble_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );
  int checks = 0;
  int failures = 0;
  logic [3:0] q[$];
  int m_rem = 0;
  logic [3:0] m_data = 4'h0;
  logic [7:0] m_frames = 8'h00;
  logic en_s, emp_s, rd_s;
  logic [3:0] front_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // a frame is a list of line levels, each held CPB cycles, after two setup cycles
  function automatic logic exp_tx(input int p, input logic [3:0] d);
    int k;
    if (p < 2) return 1'b1;
    k = (p - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
`ifdef TX_PARITY_EN
    if (k == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  always begin
    @(negedge clk);
    if (!reset) begin
      chk("tx", {31'b0, ifc.tx}, {31'b0, (m_rem == 0) ? 1'b1 : exp_tx(TOT - m_rem, m_data)});
      chk("fifo_rd", {31'b0, ifc.fifo_rd}, {31'b0, m_rem == TOT});
      chk("busy", {31'b0, ifc.busy}, {31'b0, m_rem != 0});
      chk("frames_sent", {24'b0, ifc.frames_sent}, {24'b0, m_frames});
    end
    #4;
    en_s = ifc.tx_en;
    emp_s = ifc.fifo_empty;
    rd_s = ifc.fifo_rd;
    front_s = (q.size() != 0) ? q[0] : 4'h0;
    @(posedge clk);
    #1;
    if (rd_s && q.size() != 0) begin
      ifc.fifo_dout = q.pop_front();
      ifc.fifo_empty = (q.size() == 0);
    end
    if (reset) begin
      m_rem = 0;
      m_frames = 8'h00;
    end else if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) m_frames++;
    end else if (en_s && !emp_s) begin
      m_rem = TOT;
      m_data = front_s;
    end
  end

  task automatic push(input logic [3:0] v);
    q.push_back(v);
    ifc.fifo_empty = 1'b0;
  endtask

  task automatic wait_rd();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifc.fifo_rd) begin
        ok = 1;
        break;
      end
    end
    chk("wait_rd_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!ifc.busy && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  // called at the negedge of the fetch cycle; samples mid-bit
  task automatic check_frame(input logic [7:0] pat, input int n);
    repeat (3) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("frame_bit%0d", k), {31'b0, ifc.tx}, {31'b0, pat[k]});
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic count_rd(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifc.fifo_rd) cnt++;
    end
  endtask

  initial begin
    int cnt;
    ifc.tx_en = 1'b0;
    ifc.fifo_empty = 1'b1;
    ifc.fifo_dout = 4'h0;
    #1 reset = 1'b1;
    #1;
    chk("rst_tx", {31'b0, ifc.tx}, 32'd1);
    chk("rst_busy", {31'b0, ifc.busy}, 32'd0);
    chk("rst_fifo_rd", {31'b0, ifc.fifo_rd}, 32'd0);
    chk("rst_frames", {24'b0, ifc.frames_sent}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(4'hA);
    ifc.tx_en = 1'b1;
    wait_rd();
    check_frame(8'b0011_0100, 6);
    wait_idle(100);
    chk("frames_after_A", {24'b0, ifc.frames_sent}, 32'd1);
    push(4'h3);
    push(4'hC);
    push(4'h0);
    count_rd(100, cnt);
    chk("three_rd_pulses", cnt, 32'd3);
    chk("frames_after_3C0", {24'b0, ifc.frames_sent}, 32'd4);
    chk("idle_tx", {31'b0, ifc.tx}, 32'd1);
    ifc.tx_en = 1'b0;
    push(4'h9);
    count_rd(50, cnt);
    chk("disabled_rd_pulses", cnt, 32'd0);
    chk("disabled_tx", {31'b0, ifc.tx}, 32'd1);
    ifc.tx_en = 1'b1;
    @(negedge clk);
    chk("latency_rd", {31'b0, ifc.fifo_rd}, 32'd1);
    @(negedge clk);
    chk("latency_tx_wait", {31'b0, ifc.tx}, 32'd1);
    @(negedge clk);
    chk("latency_tx_start", {31'b0, ifc.tx}, 32'd0);
    wait_idle(100);
    chk("frames_after_9", {24'b0, ifc.frames_sent}, 32'd5);
    push(4'h5);
    push(4'h2);
    wait_rd();
    repeat (8) @(negedge clk);
    ifc.tx_en = 1'b0;
    count_rd(60, cnt);
    chk("drop_en_rd_pulses", cnt, 32'd0);
    chk("frames_after_5", {24'b0, ifc.frames_sent}, 32'd6);
    chk("fifo_left", q.size(), 32'd1);
    ifc.tx_en = 1'b1;
    wait_rd();
    repeat (8) @(negedge clk);
    chk("pre_reset_tx", {31'b0, ifc.tx}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_tx", {31'b0, ifc.tx}, 32'd1);
    chk("mid_reset_busy", {31'b0, ifc.busy}, 32'd0);
    chk("mid_reset_rd", {31'b0, ifc.fifo_rd}, 32'd0);
    chk("mid_reset_frames", {24'b0, ifc.frames_sent}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 255; i++) push(i[3:0]);
    wait_idle(255 * (TOT + 1) + 100);
    chk("frames_255", {24'b0, ifc.frames_sent}, 32'hFF);
    push(4'hF);
    wait_idle(100);
    chk("frames_wrap", {24'b0, ifc.frames_sent}, 32'd0);
`ifdef TX_PARITY_EN
    push(4'h7);
    wait_rd();
    check_frame(8'b0110_1110, 7);
    wait_idle(100);
    push(4'h6);
    wait_rd();
    check_frame(8'b0100_1100, 7);
    wait_idle(100);
    chk("frames_parity", {24'b0, ifc.frames_sent}, 32'd2);
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
